// File: rtl/xor_decrypt_fifo.sv
// rtl/xor_decrypt_fifo.sv - XOR decryptor feeding a first-word-fall-through plaintext FIFO
module xor_decrypt_fifo #(
    parameter int MSG_SIZE = 8,
    parameter int DEPTH    = 4
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iEn,
    input  logic                       iDecrypt,
    input  logic [MSG_SIZE-1:0]        iKey_Assembled,
    input  logic [MSG_SIZE-1:0]        iCiphertext,
    output logic                       oReady,
    output logic [MSG_SIZE-1:0]        oPlaintext,
    output logic                       oValid,
    input  logic                       iAck,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic                       oDecrypt_flag,
    output logic                       oOverflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [MSG_SIZE-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;
    logic                r_decrypt_flag;
    logic                r_overflow;

    logic                w_accept;
    logic                w_overflow;
    logic                w_pop;

    // Full blocks a push even when a pop happens in the same cycle.
    assign oReady     = (r_count != CW'(DEPTH));
    assign oValid     = (r_count != '0);
    assign w_accept   = iEn & iDecrypt & oReady;
    assign w_overflow = iEn & iDecrypt & ~oReady;
    assign w_pop      = oValid & iAck;

    // Head word falls through; forced to zero while empty so stale storage never shows.
    assign oPlaintext    = oValid ? r_mem[r_rptr] : '0;
    assign oCount        = r_count;
    assign oDecrypt_flag = r_decrypt_flag;
    assign oOverflow     = r_overflow;

    // Storage holds decrypted words; contents are don't-care after reset.
    always_ff @(posedge iClk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= iCiphertext ^ iKey_Assembled;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_accept) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky status flags, cleared only by reset.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_decrypt_flag <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_decrypt_flag <= 1'b1;
            end
            if (w_overflow) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xor_decrypt_fifo.sv
// tb/tb_xor_decrypt_fifo.sv - scoreboard bench for xor_decrypt_fifo
module tb_xor_decrypt_fifo;

    localparam int MSG_SIZE = 8;
    localparam int DEPTH    = 4;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic                iClk = 1'b0;
    logic                iRst = 1'b0;
    logic                iEn = 1'b0;
    logic                iDecrypt = 1'b0;
    logic [MSG_SIZE-1:0] iKey_Assembled = '0;
    logic [MSG_SIZE-1:0] iCiphertext = '0;
    logic                oReady;
    logic [MSG_SIZE-1:0] oPlaintext;
    logic                oValid;
    logic                iAck = 1'b0;
    logic [CW-1:0]       oCount;
    logic                oDecrypt_flag;
    logic                oOverflow;

    xor_decrypt_fifo #(.MSG_SIZE(MSG_SIZE), .DEPTH(DEPTH)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iDecrypt(iDecrypt),
        .iKey_Assembled(iKey_Assembled), .iCiphertext(iCiphertext),
        .oReady(oReady), .oPlaintext(oPlaintext), .oValid(oValid), .iAck(iAck),
        .oCount(oCount), .oDecrypt_flag(oDecrypt_flag), .oOverflow(oOverflow)
    );

    always #5 iClk = ~iClk;

    int vectors = 0;
    int miscompares = 0;

    logic [MSG_SIZE-1:0] exp_q[$];
    int m_cnt = 0;
    bit m_flag = 0;
    bit m_ovf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT presents a word that will be acked, compare with the scoreboard head.
    always @(negedge iClk) begin
        if (iRst && oValid && iAck) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got %0h expected no word", oPlaintext);
            end else begin
                logic [MSG_SIZE-1:0] e;
                e = exp_q.pop_front();
                if (oPlaintext !== e) begin
                    miscompares++;
                    $display("FAIL pop_data: got %0h expected %0h at %0t", oPlaintext, e, $time);
                end
            end
        end
    end

    task automatic check_status();
        chk("count", 32'(oCount), 32'(m_cnt));
        chk("valid", 32'(oValid), 32'(m_cnt != 0));
        chk("ready", 32'(oReady), 32'(m_cnt != DEPTH));
        chk("decrypt_flag", 32'(oDecrypt_flag), 32'(m_flag));
        chk("overflow", 32'(oOverflow), 32'(m_ovf));
        if (m_cnt == 0) chk("empty_zero", 32'(oPlaintext), 32'h0);
    endtask

    // One clock of stimulus; the model is a plain queue of expected words plus an occupancy count.
    task automatic step(input bit en, input bit dec, input logic [MSG_SIZE-1:0] ct,
                        input logic [MSG_SIZE-1:0] key, input bit ack);
        bit full, acc, pop;
        iEn = en; iDecrypt = dec; iCiphertext = ct; iKey_Assembled = key; iAck = ack;
        full = (m_cnt == DEPTH);
        acc  = en && dec && !full;
        pop  = ack && (m_cnt != 0);
        if (acc) exp_q.push_back(ct ^ key);
        if (acc) m_flag = 1;
        if (en && dec && full) m_ovf = 1;
        m_cnt = m_cnt + int'(acc) - int'(pop);
        @(posedge iClk);
        #1;
        check_status();
    endtask

    task automatic idle();
        iEn = 0; iDecrypt = 0; iAck = 0;
    endtask

    // Reset pulsed between edges; state must clear on assertion, not at the next edge.
    task automatic do_reset();
        idle();
        #2;
        iRst = 0;
        #1;
        chk("rst_count", 32'(oCount), 32'h0);
        chk("rst_valid", 32'(oValid), 32'h0);
        chk("rst_data", 32'(oPlaintext), 32'h0);
        chk("rst_flag", 32'(oDecrypt_flag), 32'h0);
        chk("rst_ovf", 32'(oOverflow), 32'h0);
        exp_q.delete();
        m_cnt = 0; m_flag = 0; m_ovf = 0;
        #1;
        iRst = 1;
        @(posedge iClk);
        #1;
        check_status();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1;
        check_status();

        // One word: 5A ^ 3C = 66, then pop.
        step(1, 1, 8'h5A, 8'h3C, 0);
        chk("t1_head", 32'(oPlaintext), 32'h66);
        step(0, 0, 8'h00, 8'h00, 1);

        // Fill with key FF, then overflow on the fifth word, then drain.
        for (int i = 0; i < 4; i++) step(1, 1, 8'(i), 8'hFF, 0);
        step(1, 1, 8'h04, 8'hFF, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h00, 1);
        chk("t2_drained", 32'(exp_q.size()), 32'h0);

        // Full with simultaneous push and pop: push rejected, then accepted next cycle.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 8'($urandom), 8'($urandom), 0);
        step(1, 1, 8'h11, 8'h22, 1);
        chk("t3_ovf", 32'(oOverflow), 32'h1);
        step(1, 1, 8'h33, 8'h44, 0);

        // Steady stream at occupancy 2 with changing keys.
        step(0, 0, 8'h00, 8'h00, 1);
        step(0, 0, 8'h00, 8'h00, 1);
        for (int i = 0; i < 10; i++) step(1, 1, 8'($urandom), 8'($urandom), 1);

        // Enable gating: strobes ignored, draining continues.
        for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 8'($urandom), 0);
        step(0, 1, 8'h00, 8'h00, 1);
        step(0, 1, 8'h00, 8'h00, 1);

        // Reset mid-operation, then A5 ^ 0F = AA.
        for (int i = 0; i < 3; i++) step(1, 1, 8'($urandom), 8'($urandom), 0);
        do_reset();
        step(1, 1, 8'hA5, 8'h0F, 0);
        chk("t6_head", 32'(oPlaintext), 32'hAA);
        step(0, 0, 8'h00, 8'h00, 1);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                 8'($urandom), 8'($urandom), $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 8'h00, 1);
        chk("final_drained", 32'(exp_q.size()), 32'h0);

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
